interrupt_sequencer: RTL and testbench

Sequencer that runs the 6502 interrupt-entry micro-sequence (RESET, NMI, IRQ, BRK) on behalf of the CPU core. It drives the bus for the seven-cycle entry:
- a dummy read;
- three stack pushes (or three dummy stack reads for RESET);
- the two vector fetches;
- a PC load.

It sits between the interrupt controller (its `int_out`/`nmi_out` flags feed `int_req`/`nmi_pend`) and the CPU bus mux, and returns `int_clr`/`nmi_clr` to that controller. The whole block runs on Phi1.

---
 rtl/interrupt_sequencer_if.sv | 40 ++++
 rtl/interrupt_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
//
// Bus bundle between the interrupt sequencer and the CPU bus mux.
//
// Signals:
//   addr  - 16-bit bus address driven by the sequencer
//   dout  - 8-bit write data driven by the sequencer
//   rw    - 1 = read, 0 = write, driven by the sequencer
//   din   - 8-bit read data returned by the memory side, valid at the end of
//           a read cycle
//
// Modports:
//   master - sequencer side (drives addr/dout/rw, samples din)
//   slave  - memory/bus-mux side (samples addr/dout/rw, drives din)
//
// Handshake: there is no valid/ready pair on this bus. Every cycle in which
// the sequencer is busy is a bus cycle. addr/rw/dout are stable for the whole
// cycle, and din is sampled on the rising edge that ends the cycle.
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        rw;

  modport master (
    output addr,
    output dout,
    output rw,
    input  din
  );

  modport slave (
    input  addr,
    input  dout,
    input  rw,
    output din
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Runs the 6502 interrupt-entry micro-sequence (RESET, NMI, IRQ, BRK) on behalf
// of the CPU core. It performs seven bus cycles:
//   1. dummy read at the latched PC
//   2-4. three stack pushes (dummy stack reads for RESET)
//   5-6. two vector fetches
//   7. PC load
// The whole block is clocked by Phi1.
//
// Ports:
//   clk_ph1   in   Phi1 clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   int_req   in   hardware interrupt pending (sampled when a start is possible)
//   nmi_pend  in   NMI pending (sampled on the edge leaving PUSH_P)
//   brk       in   BRK opcode fetched this cycle (sampled when a start is possible)
//   pc        in   current PC (address after the opcode byte)
//   sp        in   live stack pointer; the owner decrements it on sp_dec
//   p         in   current status register
//   bus       if   master side of the bus: addr, dout, rw out; din in
//   busy      out  sequence in progress, CPU core stalls
//   sp_dec    out  decrement SP at the end of this cycle
//   pc_out    out  new PC assembled from the vector fetches
//   pc_load   out  1-cycle strobe: load pc_out into PC
//   set_i     out  1-cycle strobe: set the I flag
//   int_clr   out  1-cycle strobe: clear the controller's perform-interrupt flag
//   nmi_clr   out  1-cycle strobe: clear the controller's NMI-pending flag
//   dbg_state out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic                   clk_ph1,
  input  logic                   rst,
  input  logic                   int_req,
  input  logic                   nmi_pend,
  input  logic                   brk,
  input  logic [15:0]            pc,
  input  logic [7:0]             sp,
  input  logic [7:0]             p,
  interrupt_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   sp_dec,
  output logic [15:0]            pc_out,
  output logic                   pc_load,
  output logic                   set_i,
  output logic                   int_clr,
  output logic                   nmi_clr,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DUMMY  = 3'd1,
    PUSH_H = 3'd2,
    PUSH_L = 3'd3,
    PUSH_P = 3'd4,
    VEC_L  = 3'd5,
    VEC_H  = 3'd6,
    LOAD   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_HW    = 2'd1,
    KIND_SW    = 2'd2
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q;
  logic        rst_pend_q;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [15:0] vec_q;
  logic        nmi_hit_q;
  logic [15:0] pc_out_q;

  // Start decode. A start is possible from IDLE and also on the edge leaving
  // LOAD, which gives back-to-back sequences without an idle cycle. These
  // input-derived terms only feed registers, never the outputs.
  logic start_window;
  logic start_reset;
  logic start_hw;
  logic start_sw;
  logic do_start;

  assign start_window = (state_q == IDLE) || (state_q == LOAD);
  assign start_reset  = rst_pend_q;
  assign start_hw     = !rst_pend_q && int_req;
  assign start_sw     = !rst_pend_q && !int_req && brk;
  assign do_start     = start_window && (start_reset || start_hw || start_sw);

  // State register
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = do_start ? DUMMY : IDLE;
      DUMMY:   state_d = PUSH_H;
      PUSH_H:  state_d = PUSH_L;
      PUSH_L:  state_d = PUSH_P;
      PUSH_P:  state_d = VEC_L;
      VEC_L:   state_d = VEC_H;
      VEC_H:   state_d = LOAD;
      LOAD:    state_d = do_start ? DUMMY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched PC/P, kind, vector, assembled new PC.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      rst_pend_q <= 1'b1;
      kind_q     <= KIND_HW;
      pc_q       <= 16'h0000;
      p_q        <= 8'h00;
      vec_q      <= 16'h0000;
      nmi_hit_q  <= 1'b0;
      pc_out_q   <= 16'h0000;
    end else begin
      if (do_start) begin
        p_q <= p;
        if (start_reset) begin
          kind_q     <= KIND_RESET;
          pc_q       <= pc;
          rst_pend_q <= 1'b0;
        end else if (start_hw) begin
          kind_q <= KIND_HW;
          pc_q   <= pc;
        end else begin
          // BRK returns past its padding byte; the add wraps at 16 bits.
          kind_q <= KIND_SW;
          pc_q   <= pc + 16'd1;
        end
      end

      // Vector choice is made as late as possible so that an NMI arriving
      // during the pushes can still hijack an IRQ or BRK.
      if (state_q == PUSH_P) begin
        if (kind_q == KIND_RESET) begin
          vec_q     <= 16'hFFFC;
          nmi_hit_q <= 1'b0;
        end else if (nmi_pend) begin
          vec_q     <= 16'hFFFA;
          nmi_hit_q <= 1'b1;
        end else begin
          vec_q     <= 16'hFFFE;
          nmi_hit_q <= 1'b0;
        end
      end

      if (state_q == VEC_L) begin
        pc_out_q[7:0] <= bus.din;
      end
      if (state_q == VEC_H) begin
        pc_out_q[15:8] <= bus.din;
      end
    end
  end

  // Status byte pushed to the stack: B set only for BRK, bit 5 always set.
  logic [7:0] push_p;
  assign push_p = (kind_q == KIND_SW) ? (p_q | 8'h30) : ((p_q & 8'hEF) | 8'h20);

  // Output decode from registered state. In IDLE every output holds its reset
  // value, so an asynchronous reset mid-sequence stops bus activity at once.
  // Stack addresses track the live SP, which its owner decrements on sp_dec.
  always_comb begin
    busy     = 1'b0;
    bus.addr = 16'h0000;
    bus.dout = 8'h00;
    bus.rw   = 1'b1;
    sp_dec   = 1'b0;
    pc_load  = 1'b0;
    set_i    = 1'b0;
    int_clr  = 1'b0;
    nmi_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      DUMMY: begin
        busy     = 1'b1;
        bus.addr = pc_q;
        int_clr  = (kind_q == KIND_HW);
      end
      PUSH_H: begin
        busy     = 1'b1;
        bus.addr = {STACK_PAGE, sp};
        bus.dout = pc_q[15:8];
        bus.rw   = (kind_q == KIND_RESET);
        sp_dec   = 1'b1;
      end
      PUSH_L: begin
        busy     = 1'b1;
        bus.addr = {STACK_PAGE, sp};
        bus.dout = pc_q[7:0];
        bus.rw   = (kind_q == KIND_RESET);
        sp_dec   = 1'b1;
      end
      PUSH_P: begin
        busy     = 1'b1;
        bus.addr = {STACK_PAGE, sp};
        bus.dout = push_p;
        bus.rw   = (kind_q == KIND_RESET);
        sp_dec   = 1'b1;
      end
      VEC_L: begin
        busy     = 1'b1;
        bus.addr = vec_q;
        nmi_clr  = nmi_hit_q;
      end
      VEC_H: begin
        busy     = 1'b1;
        bus.addr = vec_q + 16'd1;
      end
      LOAD: begin
        busy     = 1'b1;
        bus.addr = pc_out_q;
        pc_load  = 1'b1;
        set_i    = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pc_out    = pc_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Directed and randomized interrupt-entry sequences. A reference model builds
// the seven expected bus cycles of each sequence from the entry rules. These
// are kept in exp_q and compared cycle by cycle at the falling edge. The bench
// also acts as the SP owner and as the vector memory.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  // Clock/reset
  logic clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;

  logic        rst;
  logic        int_req;
  logic        nmi_pend;
  logic        brk;
  logic [15:0] pc;
  logic [7:0]  sp;
  logic [7:0]  p;
  logic        busy;
  logic        sp_dec;
  logic [15:0] pc_out;
  logic        pc_load;
  logic        set_i;
  logic        int_clr;
  logic        nmi_clr;
  logic [2:0]  dbg_state;

  interrupt_sequencer_if bus();

  interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .int_req   (int_req),
    .nmi_pend  (nmi_pend),
    .brk       (brk),
    .pc        (pc),
    .sp        (sp),
    .p         (p),
    .bus       (bus),
    .busy      (busy),
    .sp_dec    (sp_dec),
    .pc_out    (pc_out),
    .pc_load   (pc_load),
    .set_i     (set_i),
    .int_clr   (int_clr),
    .nmi_clr   (nmi_clr),
    .dbg_state (dbg_state)
  );

  // Vector memory FFFA..FFFF; all other addresses read as a filler byte.
  logic [7:0] vtab [0:5];

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    logic [15:0] idx;
    if (a >= 16'hFFFA) begin
      idx = a - 16'hFFFA;
      return vtab[idx[2:0]];
    end
    return 8'hEA;
  endfunction

  assign bus.din = mem_rd(bus.addr);

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [30:0] exp_q[$];
  bit rst_pend_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One bus cycle as {busy, addr, rw, dout, sp_dec, pc_load, set_i, int_clr, nmi_clr}.
  // Write data only matters on writes, so it is zeroed for reads on both sides.
  function automatic logic [30:0] pk(input logic b, input logic [15:0] a, input logic r,
                                     input logic [7:0] d, input logic sd, input logic pl,
                                     input logic si, input logic ic, input logic nc);
    return {b, a, r, (r ? 8'h00 : d), sd, pl, si, ic, nc};
  endfunction

  function automatic logic [30:0] observed();
    return pk(busy, bus.addr, bus.rw, bus.dout, sp_dec, pc_load, set_i, int_clr, nmi_clr);
  endfunction

  // Driver: advance one clock, acting as SP owner, and return at the falling edge.
  task automatic step();
    logic d;
    d = sp_dec;
    @(posedge clk_ph1);
    #1;
    if (d) sp = sp - 8'd1;
    @(negedge clk_ph1);
  endtask

  // Runs one entry sequence from the falling edge before its start edge.
  //   rise     : cycle index (0=DUMMY..6=LOAD) at whose middle nmi_pend rises; >6 never
  //   abort_at : cycle index at which rst is asserted; >6 never
  //   keep     : leave int_req/brk asserted so a new sequence starts leaving LOAD
  //   started  : the start edge has already happened (back-to-back follow-up)
  task automatic run_seq(input bit ir, input bit bk, input logic [15:0] pcv,
                         input logic [7:0] pv, input logic [7:0] spv, input bit nmi0,
                         input int rise, input int abort_at, input bit keep,
                         input bit started, input string name);
    int          kind;  // 0 reset, 1 hardware, 2 software
    logic [15:0] pcq;
    logic [15:0] vec;
    logic [15:0] newpc;
    logic [7:0]  pushp;
    logic [7:0]  s;
    logic [7:0]  pb [0:2];
    bit          nmi_eff;
    logic [30:0] e;
    logic [15:0] vi;

    int_req  = ir;
    brk      = bk;
    pc       = pcv;
    p        = pv;
    nmi_pend = nmi0;
    if (!started) sp = spv;

    if (rst_pend_m)  kind = 0;
    else if (ir)     kind = 1;
    else             kind = 2;

    pcq     = (kind == 2) ? pcv + 16'd1 : pcv;
    pushp   = (kind == 2) ? (pv | 8'h30) : ((pv & 8'hEF) | 8'h20);
    nmi_eff = (kind != 0) && (nmi0 || (rise <= 3));
    vec     = (kind == 0) ? 16'hFFFC : (nmi_eff ? 16'hFFFA : 16'hFFFE);
    vi      = vec - 16'hFFFA;
    newpc   = {vtab[vi[2:0] + 3'd1], vtab[vi[2:0]]};
    pb[0]   = pcq[15:8];
    pb[1]   = pcq[7:0];
    pb[2]   = pushp;

    exp_q.delete();
    exp_q.push_back(pk(1'b1, pcq, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, (kind == 1), 1'b0));
    s = sp;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(pk(1'b1, {8'h01, s}, (kind == 0), pb[j], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      s = s - 8'd1;
    end
    exp_q.push_back(pk(1'b1, vec, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, nmi_eff));
    exp_q.push_back(pk(1'b1, vec + 16'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pk(1'b1, newpc, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));

    if (!started) begin
      chk($sformatf("%s_idle_busy", name), busy, 1'b0);
      step();
    end
    if (kind == 0) rst_pend_m = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (i == 0 && !keep) begin
        int_req = 1'b0;
        brk     = 1'b0;
      end
      if (i == rise) nmi_pend = 1'b1;
      e = exp_q.pop_front();
      chk($sformatf("%s_c%0d", name, i), observed(), e);
      if (i == 6) chk($sformatf("%s_pc_out", name), pc_out, newpc);
      if (i == abort_at) begin
        rst        = 1'b1;
        rst_pend_m = 1'b1;
        #1;
        chk($sformatf("%s_abort", name), observed(),
            pk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        chk($sformatf("%s_abort_dout", name), bus.dout, 8'h00);
        exp_q.delete();
        return;
      end
      step();
    end
    chk($sformatf("%s_end_busy", name), busy, keep);
  endtask

  // Stimulus
  initial begin
    rst        = 1'b1;
    int_req    = 1'b0;
    nmi_pend   = 1'b0;
    brk        = 1'b0;
    pc         = 16'h0000;
    sp         = 8'h00;
    p          = 8'h00;
    rst_pend_m = 1'b1;
    vtab[0] = 8'h00; vtab[1] = 8'h90;  // FFFA -> 9000
    vtab[2] = 8'h00; vtab[3] = 8'h80;  // FFFC -> 8000
    vtab[4] = 8'h00; vtab[5] = 8'hA0;  // FFFE -> A000

    // Reset values while rst is held
    @(negedge clk_ph1);
    @(negedge clk_ph1);
    chk("rst_outputs", observed(), pk(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_pc_out", pc_out, 16'h0000);
    rst = 1'b0;

    // Reset sequence with SP wrapping through 00 -> FF
    run_seq(1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0, 7, 99, 1'b0, 1'b0, "reset");
    // IRQ
    run_seq(1'b1, 1'b0, 16'hC123, 8'h01, 8'hFF, 1'b0, 7, 99, 1'b0, 1'b0, "irq");
    // BRK
    run_seq(1'b0, 1'b1, 16'h8001, 8'h00, 8'hFF, 1'b0, 7, 99, 1'b0, 1'b0, "brk");
    // NMI hijack of an IRQ, nmi_pend rising during PUSH_L
    run_seq(1'b1, 1'b0, 16'hC123, 8'h01, 8'hFF, 1'b0, 2, 99, 1'b0, 1'b0, "nmi_hijack");
    // NMI rising after the vector choice has no effect
    run_seq(1'b1, 1'b0, 16'h5555, 8'hFF, 8'h80, 1'b0, 4, 99, 1'b0, 1'b0, "nmi_late");
    // int_req and brk together: hardware kind wins
    run_seq(1'b1, 1'b1, 16'h2000, 8'h10, 8'hFF, 1'b0, 7, 99, 1'b0, 1'b0, "irq_brk");
    // BRK at FFFF wraps to 0000
    run_seq(1'b0, 1'b1, 16'hFFFF, 8'h00, 8'hFF, 1'b0, 7, 99, 1'b0, 1'b0, "brk_wrap");
    // BRK hijacked by an already-pending NMI
    run_seq(1'b0, 1'b1, 16'h3000, 8'h04, 8'h40, 1'b1, 7, 99, 1'b0, 1'b0, "brk_nmi");
    // Back-to-back: a second IRQ starts on the edge leaving LOAD
    run_seq(1'b1, 1'b0, 16'h4000, 8'h00, 8'hFF, 1'b0, 7, 99, 1'b1, 1'b0, "b2b_a");
    run_seq(1'b1, 1'b0, 16'h4000, 8'h00, 8'h00, 1'b0, 7, 99, 1'b0, 1'b1, "b2b_b");

    // Reset mid-sequence during PUSH_L, then a full reset sequence with no writes
    run_seq(1'b1, 1'b0, 16'h6000, 8'h00, 8'hFF, 1'b0, 7, 2, 1'b0, 1'b0, "abort");
    step();
    chk("abort_hold_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    run_seq(1'b1, 1'b1, 16'h6000, 8'h00, sp, 1'b0, 7, 99, 1'b0, 1'b0, "reset2");

    // Randomized sequences
    for (int n = 0; n < 24; n++) begin
      bit          ir;
      bit          bk;
      for (int k = 0; k < 6; k++) vtab[k] = 8'($urandom_range(0, 255));
      ir = 1'($urandom_range(0, 1));
      bk = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      run_seq(ir, bk, 16'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 3) == 0), $urandom_range(0, 8), 99, 1'b0, 1'b0,
              $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
